// File: rtl/led_pkg.sv
// Shared definitions for the io_led output blocks: default geometry and the
// pending-slot state encoding.
package led_pkg;

    localparam int LED_WIDTH    = 24;
    localparam int LED_PWM_BITS = 8;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: a prescaler that paces PWM steps and a free-running PWM counter.
// step and boundary are combinational decodes of the registered counters.
module led_pwm_timebase #(
    parameter int PRESCALE = 16,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                step,
    output logic                boundary
);

    // A one-bit prescaler is kept even when PRESCALE==1; it then sits at zero.
    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]       r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_step;

    assign w_step   = (r_presc == PRESC_MAX);
    assign step     = w_step;
    assign boundary = w_step && (r_pwm_cnt == '1);
    assign pwm_cnt  = r_pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (w_step) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end else begin
            r_presc   <= r_presc + PW'(1);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED array output stage: a one-deep pending slot feeds the active pattern/duty,
// swapped only on PWM frame boundaries, and io_led is the PWM-gated active pattern.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int WIDTH    = LED_WIDTH,
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    pattern_in,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic                load_valid,
    output logic                load_ready,
    output logic [WIDTH-1:0]    io_led,
    output logic                frame_start
);

    generate
        if (PRESCALE < 1 || PWM_BITS < 1 || PWM_BITS > 16) begin : g_param_check
            $error("led_pwm_driver: PRESCALE must be >= 1 and PWM_BITS within 1..16");
        end
    endgenerate

    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_step;
    logic                w_boundary;
    logic                w_swap;

    pend_state_t         r_state;
    logic [WIDTH-1:0]    r_pend_pattern;
    logic [PWM_BITS-1:0] r_pend_duty;
    logic [WIDTH-1:0]    r_act_pattern;
    logic [PWM_BITS-1:0] r_act_duty;
    logic [WIDTH-1:0]    r_io_led;
    logic                r_frame_start;

    led_pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .pwm_cnt  (w_pwm_cnt),
        .step     (w_step),
        .boundary (w_boundary)
    );

    assign w_swap      = w_step && w_boundary;
    assign load_ready  = (r_state == PEND_EMPTY);
    assign io_led      = r_io_led;
    assign frame_start = r_frame_start;

    // While FULL the load port is ignored, so a held load_valid waits for the swap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= PEND_EMPTY;
            r_pend_pattern <= '0;
            r_pend_duty    <= '0;
            r_act_pattern  <= '0;
            r_act_duty     <= '0;
            r_io_led       <= '0;
            r_frame_start  <= 1'b0;
        end else begin
            r_io_led      <= r_act_pattern & {WIDTH{w_pwm_cnt < r_act_duty}};
            r_frame_start <= w_boundary;
            if (r_state == PEND_EMPTY) begin
                if (load_valid) begin
                    r_pend_pattern <= pattern_in;
                    r_pend_duty    <= duty_in;
                    r_state        <= PEND_FULL;
                end
            end else begin
                if (w_swap) begin
                    r_act_pattern <= r_pend_pattern;
                    r_act_duty    <= r_pend_duty;
                    r_state       <= PEND_EMPTY;
                end
            end
        end
    end

endmodule
